// File: rtl/a51_stream_xor_pkg.sv
// a51_pkg: shared definitions for the A5/1 keystream XOR stage.
//   a51_state_e      - control FSM states (IDLE, DISCARD, PACK, XOR)
//   A51_DISCARD_BITS - default number of keystream bits dropped per frame
//   A51_FRAME_BYTES  - default number of bytes encrypted per frame
package a51_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_PACK    = 2'd2,
    ST_XOR     = 2'd3
  } a51_state_e;

  localparam int unsigned A51_DISCARD_BITS = 100;
  localparam int unsigned A51_FRAME_BYTES  = 14;

endpackage

// File: rtl/a51_ks_packer.sv
// a51_ks_packer: keystream front end. Drops the mixing-phase bits, then packs
// accepted bits MSB-first into a byte.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   discard_en     - controller is in the discard phase
//   pack_en        - controller is in the pack phase
//   consume        - the packed byte was used; clears byte_rdy
//   ks_bit/ks_valid- keystream input (accepted when the matching *_en is high)
//   discard_done   - the last discard bit is accepted this cycle
//   byte_done      - the 8th pack bit is accepted this cycle
//   byte_rdy       - a packed byte is held and not yet consumed
//   ks_byte        - packed keystream byte (first accepted bit in bit 7)
module a51_ks_packer
  import a51_pkg::*;
#(
  parameter int unsigned DISCARD_BITS = A51_DISCARD_BITS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       discard_en,
  input  logic       pack_en,
  input  logic       consume,
  input  logic       ks_bit,
  input  logic       ks_valid,
  output logic       discard_done,
  output logic       byte_done,
  output logic       byte_rdy,
  output logic [7:0] ks_byte
);

  // Counter only has to reach DISCARD_BITS-1; it returns to 0 on the last bit.
  localparam int unsigned CW = (DISCARD_BITS > 1) ? $clog2(DISCARD_BITS) : 1;

  logic [CW-1:0] disc_cnt_q, disc_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          rdy_q, rdy_d;
  logic          disc_acc, pack_acc;

  always_comb begin
    disc_acc     = discard_en && ks_valid;
    pack_acc     = pack_en && ks_valid;
    // With DISCARD_BITS==0 the right side never matches; discard_en is never
    // raised in that configuration anyway.
    discard_done = disc_acc && (32'(disc_cnt_q) == DISCARD_BITS - 32'd1);
    byte_done    = pack_acc && (bit_cnt_q == 3'd7);

    disc_cnt_d = disc_cnt_q;
    if (disc_acc) begin
      disc_cnt_d = discard_done ? '0 : disc_cnt_q + 1'b1;
    end

    bit_cnt_d = pack_acc ? bit_cnt_q + 3'd1 : bit_cnt_q;
    shift_d   = pack_acc ? {shift_q[6:0], ks_bit} : shift_q;

    rdy_d = rdy_q;
    if (consume) begin
      rdy_d = 1'b0;
    end
    if (byte_done) begin
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disc_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rdy_q      <= 1'b0;
    end else begin
      disc_cnt_q <= disc_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rdy_q      <= rdy_d;
    end
  end

  assign ks_byte  = shift_q;
  assign byte_rdy = rdy_q;

endmodule

// File: rtl/a51_stream_xor.sv
// a51_stream_xor: XORs plaintext bytes with packed A5/1 keystream bytes.
// Per frame: drop DISCARD_BITS keystream bits, then for each of FRAME_BYTES
// bytes pack 8 keystream bits and XOR them with one plaintext byte.
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   start                       - one-cycle frame start (honoured only in IDLE)
//   ks_bit/ks_valid/ks_ready    - keystream bit input handshake
//   pt_data/pt_valid/pt_ready   - plaintext byte input handshake
//   ct_data/ct_valid/ct_ready   - registered ciphertext output handshake
//   busy                        - FSM is not in IDLE
//   frame_done                  - pulses the cycle after the last byte's accept
//   frame_cnt[15:0]             - completed frames, wrapping (only when the
//                                 macro A51_STREAM_XOR_FRAME_CNT_EN is defined)
module a51_stream_xor
  import a51_pkg::*;
#(
  parameter int unsigned DISCARD_BITS = A51_DISCARD_BITS,
  parameter int unsigned FRAME_BYTES  = A51_FRAME_BYTES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        ks_bit,
  input  logic        ks_valid,
  output logic        ks_ready,
  input  logic [7:0]  pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [7:0]  ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        busy,
  output logic        frame_done
`ifdef A51_STREAM_XOR_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  a51_state_e state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] ct_data_q, ct_data_d;
  logic       ct_valid_q, ct_valid_d;
  logic       frame_done_q, frame_done_d;

  logic       discard_done, byte_done, byte_rdy;
  logic [7:0] ks_byte;
  logic       pt_acc, last_byte;

  a51_ks_packer #(
    .DISCARD_BITS(DISCARD_BITS)
  ) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .discard_en  (state_q == ST_DISCARD),
    .pack_en     (state_q == ST_PACK),
    .consume     (pt_acc),
    .ks_bit      (ks_bit),
    .ks_valid    (ks_valid),
    .discard_done(discard_done),
    .byte_done   (byte_done),
    .byte_rdy    (byte_rdy),
    .ks_byte     (ks_byte)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ct_data_d    = ct_data_q;
    ct_valid_d   = ct_valid_q;
    frame_done_d = 1'b0;

    ks_ready  = (state_q == ST_DISCARD) || (state_q == ST_PACK);
    pt_ready  = (state_q == ST_XOR) && byte_rdy && (!ct_valid_q || ct_ready);
    pt_acc    = pt_valid && pt_ready;
    last_byte = (32'(byte_cnt_q) + 32'd1) >= FRAME_BYTES;

    // Drain first, then load, so a same-cycle load keeps ct_valid high.
    if (ct_valid_q && ct_ready) begin
      ct_valid_d = 1'b0;
    end
    if (pt_acc) begin
      ct_data_d  = pt_data ^ ks_byte;
      ct_valid_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (DISCARD_BITS == 0) ? ST_PACK : ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (discard_done) begin
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        if (byte_done) begin
          state_d = ST_XOR;
        end
      end
      ST_XOR: begin
        if (pt_acc) begin
          if (last_byte) begin
            state_d      = ST_IDLE;
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            state_d    = ST_PACK;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      ct_data_q    <= '0;
      ct_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ct_data_q    <= ct_data_d;
      ct_valid_q   <= ct_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ct_data    = ct_data_q;
  assign ct_valid   = ct_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef A51_STREAM_XOR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (frame_done_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_a51_stream_xor.sv
// Directed bench for a51_stream_xor (DISCARD_BITS=100, FRAME_BYTES=2).
// Reference frame: 100 discard bits of 1, keystream bytes 0xB3 and 0x0F,
// plaintext 0xFF and 0x00 -> ciphertext 0x4C and 0x0F.
module tb_a51_stream_xor;

  localparam int unsigned TB_DISCARD = 100;
  localparam int unsigned TB_FRAME   = 2;
  localparam int unsigned BUDGET     = 300;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       ks_bit, ks_valid, ks_ready;
  logic [7:0] pt_data;
  logic       pt_valid, pt_ready;
  logic [7:0] ct_data;
  logic       ct_valid, ct_ready;
  logic       busy, frame_done;
`ifdef A51_STREAM_XOR_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int unsigned vectors  = 0;
  int unsigned errors   = 0;
  int unsigned fd_count = 0;
  logic [7:0]  ct_log[$];

  a51_stream_xor #(
    .DISCARD_BITS(TB_DISCARD),
    .FRAME_BYTES (TB_FRAME)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .ks_bit    (ks_bit),
    .ks_valid  (ks_valid),
    .ks_ready  (ks_ready),
    .pt_data   (pt_data),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .ct_data   (ct_data),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef A51_STREAM_XOR_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Records frame_done pulses and every ciphertext byte actually transferred.
  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (ct_valid === 1'b1 && ct_ready === 1'b1) ct_log.push_back(ct_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_ks(input logic b, input bit stall);
    int unsigned t = 0;
    ks_bit   = b;
    ks_valid = 1'b1;
    while (ks_ready !== 1'b1 && t < BUDGET) begin
      tick();
      t++;
    end
    if (t >= BUDGET) begin
      vectors++;
      errors++;
      $display("FAIL ks_ready_wait: ks_ready=%b, required 1 within %0d cycles", ks_ready, BUDGET);
    end
    tick();
    ks_valid = 1'b0;
    if (stall) tick();
  endtask

  task automatic send_discard(input int unsigned n, input bit stall);
    for (int unsigned i = 0; i < n; i++) send_ks(1'b1, stall);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    for (int i = 7; i >= 0; i--) send_ks(b[i], stall);
  endtask

  task automatic send_pt(input logic [7:0] d);
    int unsigned t = 0;
    pt_data  = d;
    pt_valid = 1'b1;
    while (pt_ready !== 1'b1 && t < BUDGET) begin
      tick();
      t++;
    end
    if (t >= BUDGET) begin
      vectors++;
      errors++;
      $display("FAIL pt_ready_wait: pt_ready=%b, required 1 within %0d cycles", pt_ready, BUDGET);
    end
    tick();
    pt_valid = 1'b0;
  endtask

  task automatic run_frame(input bit stall);
    pulse_start();
    send_discard(TB_DISCARD, stall);
    send_byte(8'hB3, stall);
    send_pt(8'hFF);
    send_byte(8'h0F, stall);
    send_pt(8'h00);
    tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    ks_bit   = 1'b0;
    ks_valid = 1'b0;
    pt_data  = 8'h00;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({ct_valid, frame_done, busy, ks_ready, pt_ready, ct_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: {ct_valid,frame_done,busy,ks_ready,pt_ready,ct_data}=%b, required all 0",
               {ct_valid, frame_done, busy, ks_ready, pt_ready, ct_data});
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({busy, ks_ready, pt_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: {busy,ks_ready,pt_ready}=%b, required 000", {busy, ks_ready, pt_ready});
    end
  endtask

  task automatic test_basic_frame();
    int unsigned fd0 = fd_count;
    int unsigned n0  = ct_log.size();
    pulse_start();
    vectors++;
    if ({busy, ks_ready, pt_ready} !== 3'b110) begin
      errors++;
      $display("FAIL basic_discard_state: {busy,ks_ready,pt_ready}=%b, required 110", {busy, ks_ready, pt_ready});
    end
    send_discard(TB_DISCARD, 1'b0);
    send_byte(8'hB3, 1'b0);
    vectors++;
    if ({ks_ready, pt_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_xor_state: {ks_ready,pt_ready}=%b, required 01", {ks_ready, pt_ready});
    end
    send_pt(8'hFF);
    vectors++;
    if (ct_valid !== 1'b1 || ct_data !== 8'h4C || ks_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ct0: ct_valid=%b ct_data=%h ks_ready=%b, required 1 4c 1", ct_valid, ct_data, ks_ready);
    end
    send_byte(8'h0F, 1'b0);
    send_pt(8'h00);
    vectors++;
    if (ct_valid !== 1'b1 || ct_data !== 8'h0F || frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ct1: ct_valid=%b ct_data=%h frame_done=%b busy=%b, required 1 0f 1 0",
               ct_valid, ct_data, frame_done, busy);
    end
    tick();
    vectors++;
    if (frame_done !== 1'b0 || ct_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: frame_done=%b ct_valid=%b, required 0 0", frame_done, ct_valid);
    end
    tick();
    vectors++;
    if (fd_count - fd0 != 1) begin
      errors++;
      $display("FAIL basic_frame_done_count: got %0d pulses, required 1", fd_count - fd0);
    end
    vectors++;
    if (ct_log.size() != n0 + 2 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F) begin
      errors++;
      $display("FAIL basic_ct_stream: got %0d bytes, required 2 bytes 4c 0f", ct_log.size() - n0);
    end
  endtask

  task automatic test_backpressure();
    int unsigned n0 = ct_log.size();
    pulse_start();
    send_discard(TB_DISCARD, 1'b0);
    send_byte(8'hB3, 1'b0);
    ct_ready = 1'b0;
    send_pt(8'hFF);
    send_byte(8'h0F, 1'b0);
    pt_data  = 8'h00;
    pt_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (pt_ready !== 1'b0 || ct_valid !== 1'b1 || ct_data !== 8'h4C) begin
        errors++;
        $display("FAIL bp_hold[%0d]: pt_ready=%b ct_valid=%b ct_data=%h, required 0 1 4c",
                 i, pt_ready, ct_valid, ct_data);
      end
      tick();
    end
    ct_ready = 1'b1;
    tick();
    pt_valid = 1'b0;
    vectors++;
    if (ct_valid !== 1'b1 || ct_data !== 8'h0F || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_load_wins: ct_valid=%b ct_data=%h frame_done=%b, required 1 0f 1",
               ct_valid, ct_data, frame_done);
    end
    tick();
    vectors++;
    if (ct_log.size() != n0 + 2 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F) begin
      errors++;
      $display("FAIL bp_ct_stream: got %0d bytes, required 2 bytes 4c 0f", ct_log.size() - n0);
    end
  endtask

  task automatic test_ks_stall();
    int unsigned fd0 = fd_count;
    int unsigned n0  = ct_log.size();
    run_frame(1'b1);
    vectors++;
    if (ct_log.size() != n0 + 2 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F) begin
      errors++;
      $display("FAIL stall_ct_stream: got %0d bytes, required 2 bytes 4c 0f", ct_log.size() - n0);
    end
    vectors++;
    if (fd_count - fd0 != 1) begin
      errors++;
      $display("FAIL stall_frame_done: got %0d pulses, required 1", fd_count - fd0);
    end
  endtask

  task automatic test_start_ignored();
    int unsigned fd0 = fd_count;
    int unsigned n0  = ct_log.size();
    pulse_start();
    send_discard(50, 1'b0);
    pulse_start();
    send_discard(TB_DISCARD - 50, 1'b0);
    send_byte(8'hB3, 1'b0);
    pulse_start();
    vectors++;
    if ({busy, ks_ready, pt_ready} !== 3'b101) begin
      errors++;
      $display("FAIL start_in_xor: {busy,ks_ready,pt_ready}=%b, required 101", {busy, ks_ready, pt_ready});
    end
    send_pt(8'hFF);
    send_byte(8'h0F, 1'b0);
    send_pt(8'h00);
    tick();
    vectors++;
    if (ct_log.size() != n0 + 2 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F || fd_count - fd0 != 1) begin
      errors++;
      $display("FAIL start_ignored_frame: got %0d bytes %0d pulses, required 2 bytes 4c 0f and 1 pulse",
               ct_log.size() - n0, fd_count - fd0);
    end
  endtask

  task automatic test_start_pending();
    int unsigned n0 = ct_log.size();
    pulse_start();
    send_discard(TB_DISCARD, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_pt(8'hFF);
    send_byte(8'h0F, 1'b0);
    ct_ready = 1'b0;
    send_pt(8'h00);
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || ct_valid !== 1'b1 || ct_data !== 8'h0F) begin
      errors++;
      $display("FAIL pending_at_start: busy=%b ct_valid=%b ct_data=%h, required 1 1 0f", busy, ct_valid, ct_data);
    end
    send_discard(20, 1'b0);
    vectors++;
    if (ct_valid !== 1'b1 || ct_data !== 8'h0F) begin
      errors++;
      $display("FAIL pending_held: ct_valid=%b ct_data=%h, required 1 0f", ct_valid, ct_data);
    end
    ct_ready = 1'b1;
    tick();
    vectors++;
    if (ct_valid !== 1'b0) begin
      errors++;
      $display("FAIL pending_drain: ct_valid=%b, required 0", ct_valid);
    end
    send_discard(TB_DISCARD - 20, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_pt(8'hFF);
    send_byte(8'h0F, 1'b0);
    send_pt(8'h00);
    tick();
    vectors++;
    if (ct_log.size() != n0 + 4 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F ||
        ct_log[n0+2] !== 8'h4C || ct_log[n0+3] !== 8'h0F) begin
      errors++;
      $display("FAIL pending_ct_stream: got %0d bytes, required 4 bytes 4c 0f 4c 0f", ct_log.size() - n0);
    end
  endtask

  task automatic test_reset_mid_pack();
    int unsigned fd0;
    int unsigned n0;
    fd0 = fd_count;
    pulse_start();
    send_discard(TB_DISCARD, 1'b0);
    send_ks(1'b1, 1'b0);
    send_ks(1'b0, 1'b0);
    send_ks(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({ct_valid, frame_done, busy, ks_ready, pt_ready, ct_data} !== 13'h0) begin
      errors++;
      $display("FAIL midpack_reset_outputs: {ct_valid,frame_done,busy,ks_ready,pt_ready,ct_data}=%b, required all 0",
               {ct_valid, frame_done, busy, ks_ready, pt_ready, ct_data});
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (fd_count != fd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midpack_no_done: pulses=%0d busy=%b, required 0 pulses busy 0", fd_count - fd0, busy);
    end
    n0  = ct_log.size();
    fd0 = fd_count;
    run_frame(1'b0);
    vectors++;
    if (ct_log.size() != n0 + 2 || ct_log[n0] !== 8'h4C || ct_log[n0+1] !== 8'h0F || fd_count - fd0 != 1) begin
      errors++;
      $display("FAIL midpack_next_frame: got %0d bytes %0d pulses, required 2 bytes 4c 0f and 1 pulse",
               ct_log.size() - n0, fd_count - fd0);
    end
  endtask

  task automatic test_frame_cnt();
    int unsigned fd0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    fd0 = fd_count;
    for (int i = 0; i < 3; i++) run_frame(1'b0);
    vectors++;
    if (fd_count - fd0 != 3) begin
      errors++;
      $display("FAIL b2b_frame_done: got %0d pulses, required 3", fd_count - fd0);
    end
`ifdef A51_STREAM_XOR_FRAME_CNT_EN
    vectors++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt: got %0d, required 3", frame_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_ks_stall();
    test_start_ignored();
    test_start_pending();
    test_reset_mid_pack();
    test_frame_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
